// File: rtl/vga_source_gen.sv
// vga_source_gen: synthetic VGA transmitter.
// Generates 800x600-style timing with hsync/vsync, an RGB565 colour bus and a
// per-pixel valid strobe. It also exports the coordinates of each active pixel.
// Every output is registered: the counter state (h,v) seen in cycle n is
// presented on the outputs in cycle n+1.
//
// Ports:
//   clk          pixel clock, one pixel per cycle
//   rst_n        asynchronous active-low reset
//   enable       1 = run timing, 0 = hold counters at (0,0) with idle outputs
//   pattern_sel  0 solid, 1 colour bars, 2 checkerboard, 3 gradient
//   solid_colour colour for pattern 0 (sampled live)
//   hw_rgb_out   colour bus, 0 during blanking
//   hw_hsync_out horizontal sync
//   hw_vsync_out vertical sync
//   pixel_valid  high on active pixels only
//   pixel_x/y    coordinates of the current active pixel, 0 when invalid
//   frame_start  one-cycle pulse together with pixel (0,0)
//   frame_count  number of completed frames, wraps 255 -> 0
module vga_source_gen #(
    parameter int PRECISION        = 11,
    parameter int PIXEL_SIZE       = 16,
    parameter int X_RES            = 800,
    parameter int Y_RES            = 600,
    parameter int H_FRONT_PORCH    = 40,
    parameter int H_SYNC           = 128,
    parameter int H_BACK_PORCH     = 88,
    parameter int V_FRONT_PORCH    = 1,
    parameter int V_SYNC           = 4,
    parameter int V_BACK_PORCH     = 23,
    parameter int SYNC_ACTIVE_HIGH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic [PIXEL_SIZE-1:0] solid_colour,
    output logic [PIXEL_SIZE-1:0] hw_rgb_out,
    output logic                  hw_hsync_out,
    output logic                  hw_vsync_out,
    output logic                  pixel_valid,
    output logic [PRECISION-1:0]  pixel_x,
    output logic [PRECISION-1:0]  pixel_y,
    output logic                  frame_start,
    output logic [7:0]            frame_count
);

    localparam int H_TOTAL  = X_RES + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL  = Y_RES + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int HS_START = X_RES + H_FRONT_PORCH;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = Y_RES + V_FRONT_PORCH;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BAR_W    = X_RES / 8;
    localparam logic SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

    typedef logic [PRECISION-1:0] coord_t;
    typedef logic [PIXEL_SIZE-1:0] pix_t;

    coord_t     h_q, h_d, v_q, v_d;
    coord_t     sub_q, sub_d;
    logic [2:0] bar_q, bar_d;
    logic [1:0] pat_q, pat_d;
    pix_t       rgb_q, rgb_d;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic       valid_q, valid_d, fs_q, fs_d;
    coord_t     px_q, px_d, py_q, py_d;
    logic [7:0] fc_q, fc_d;

    logic       at_origin, h_last, v_last, active, in_hs, in_vs;
    logic [1:0] pat_cur;
    pix_t       bar_colour, pix_colour;

    always_comb begin
        at_origin = (h_q == '0) && (v_q == '0);
        h_last    = (h_q == coord_t'(H_TOTAL - 1));
        v_last    = (v_q == coord_t'(V_TOTAL - 1));
        active    = (h_q < coord_t'(X_RES)) && (v_q < coord_t'(Y_RES));
        in_hs     = (h_q >= coord_t'(HS_START)) && (h_q < coord_t'(HS_END));
        in_vs     = (v_q >= coord_t'(VS_START)) && (v_q < coord_t'(VS_END));
        // The pattern for pixel (0,0) is the one being latched this cycle.
        pat_cur   = at_origin ? pattern_sel : pat_q;

        case (bar_q)
            3'd0:    bar_colour = pix_t'(16'hFFFF);
            3'd1:    bar_colour = pix_t'(16'hFFE0);
            3'd2:    bar_colour = pix_t'(16'h07FF);
            3'd3:    bar_colour = pix_t'(16'h07E0);
            3'd4:    bar_colour = pix_t'(16'hF81F);
            3'd5:    bar_colour = pix_t'(16'hF800);
            3'd6:    bar_colour = pix_t'(16'h001F);
            default: bar_colour = pix_t'(16'h0000);
        endcase

        case (pat_cur)
            2'd0:    pix_colour = solid_colour;
            2'd1:    pix_colour = bar_colour;
            2'd2:    pix_colour = (h_q[4] ^ v_q[4]) ? pix_t'(16'hFFFF) : pix_t'(16'h0000);
            default: pix_colour = pix_t'({h_q[9:5], v_q[9:4], fc_q[4:0]});
        endcase

        // Idle defaults: counters parked at (0,0), outputs at reset values.
        h_d     = '0;
        v_d     = '0;
        sub_d   = '0;
        bar_d   = '0;
        pat_d   = pat_q;
        rgb_d   = '0;
        hs_d    = ~SYNC_ON;
        vs_d    = ~SYNC_ON;
        valid_d = 1'b0;
        px_d    = '0;
        py_d    = '0;
        fs_d    = 1'b0;
        fc_d    = fc_q;

        if (enable) begin
            h_d   = h_last ? '0 : h_q + coord_t'(1);
            v_d   = h_last ? (v_last ? '0 : v_q + coord_t'(1)) : v_q;
            fc_d  = (h_last && v_last) ? fc_q + 8'd1 : fc_q;
            pat_d = pat_cur;
            // Bar index and position within the bar track h_q without a divider;
            // both restart when the line wraps.
            if (!h_last && active) begin
                if (sub_q == coord_t'(BAR_W - 1)) begin
                    sub_d = '0;
                    bar_d = bar_q + 3'd1;
                end else begin
                    sub_d = sub_q + coord_t'(1);
                    bar_d = bar_q;
                end
            end
            hs_d = in_hs ? SYNC_ON : ~SYNC_ON;
            vs_d = in_vs ? SYNC_ON : ~SYNC_ON;
            if (active) begin
                rgb_d   = pix_colour;
                valid_d = 1'b1;
                px_d    = h_q;
                py_d    = v_q;
                fs_d    = at_origin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            sub_q   <= '0;
            bar_q   <= '0;
            pat_q   <= '0;
            rgb_q   <= '0;
            hs_q    <= ~SYNC_ON;
            vs_q    <= ~SYNC_ON;
            valid_q <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            fs_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            sub_q   <= sub_d;
            bar_q   <= bar_d;
            pat_q   <= pat_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            valid_q <= valid_d;
            px_q    <= px_d;
            py_q    <= py_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign hw_rgb_out   = rgb_q;
    assign hw_hsync_out = hs_q;
    assign hw_vsync_out = vs_q;
    assign pixel_valid  = valid_q;
    assign pixel_x      = px_q;
    assign pixel_y      = py_q;
    assign frame_start  = fs_q;
    assign frame_count  = fc_q;

endmodule

// File: tb/tb_vga_source_gen.sv
`timescale 1ns/1ps
// Bench for vga_source_gen using a reduced raster so that many frames fit in
// a short run. A reference model derives each cycle's expected outputs from
// raster arithmetic and pushes them into exp_q; a negedge monitor pops and
// compares them against the DUT outputs.
module tb_vga_source_gen;
    localparam int XR  = 64;
    localparam int YR  = 20;
    localparam int HFP = 4;
    localparam int HS  = 8;
    localparam int HBP = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HT  = XR + HFP + HS + HBP;
    localparam int VT  = YR + VFP + VS + VBP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_colour = 16'h0000;
    logic [15:0] hw_rgb_out;
    logic        hw_hsync_out, hw_vsync_out, pixel_valid, frame_start;
    logic [10:0] pixel_x, pixel_y;
    logic [7:0]  frame_count;

    vga_source_gen #(
        .PRECISION(11), .PIXEL_SIZE(16), .X_RES(XR), .Y_RES(YR),
        .H_FRONT_PORCH(HFP), .H_SYNC(HS), .H_BACK_PORCH(HBP),
        .V_FRONT_PORCH(VFP), .V_SYNC(VS), .V_BACK_PORCH(VBP),
        .SYNC_ACTIVE_HIGH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .solid_colour(solid_colour), .hw_rgb_out(hw_rgb_out),
        .hw_hsync_out(hw_hsync_out), .hw_vsync_out(hw_vsync_out),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] rgb;
        logic        hs;
        logic        vs;
        logic        valid;
        logic [10:0] x;
        logic [10:0] y;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    obs_t exp_q[$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic obs_t idle_obs(input int fc);
        obs_t o;
        o = '0;
        o.fc = 8'(fc);
        return o;
    endfunction

    // Colour of active pixel (x,y) for pattern p, straight from the pattern rules.
    function automatic logic [15:0] ref_colour(input int p, input int x, input int y,
                                               input int fc, input logic [15:0] solid);
        int bar;
        case (p)
            0: return solid;
            1: begin
                bar = x / (XR / 8);
                case (bar)
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2: return (((x / 16) % 2) != ((y / 16) % 2)) ? 16'hFFFF : 16'h0000;
            default: return 16'(((x / 32) % 32) * 2048 + ((y / 16) % 64) * 32 + (fc % 32));
        endcase
    endfunction

    // ---------------- reference model ----------------
    int mh = 0, mv = 0, mfc = 0, mpat = 0;

    always @(posedge clk or negedge rst_n) begin : model
        obs_t e;
        int   p;
        if (!rst_n) begin
            mh = 0; mv = 0; mfc = 0; mpat = 0;
            exp_q.delete();
        end else begin
            e = idle_obs(mfc);
            if (enable) begin
                p = (mh == 0 && mv == 0) ? int'(pattern_sel) : mpat;
                mpat = p;
                e.hs = (mh >= XR + HFP) && (mh < XR + HFP + HS);
                e.vs = (mv >= YR + VFP) && (mv < YR + VFP + VS);
                if (mh < XR && mv < YR) begin
                    e.valid = 1'b1;
                    e.x     = 11'(mh);
                    e.y     = 11'(mv);
                    e.rgb   = ref_colour(p, mh, mv, mfc, solid_colour);
                    e.fs    = (mh == 0 && mv == 0);
                end
                mh = mh + 1;
                if (mh == HT) begin
                    mh = 0;
                    mv = mv + 1;
                    if (mv == VT) begin
                        mv = 0;
                        mfc = (mfc + 1) % 256;
                    end
                end
                e.fc = 8'(mfc);
            end else begin
                mh = 0;
                mv = 0;
            end
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    logic timing_chk = 1'b0;
    int hs_run = 0, vs_run = 0, hs_pulses = 0, vs_pulses = 0, fs_cnt = 0, val_cnt = 0;

    always @(negedge clk) begin : monitor
        obs_t a, e;
        a = {hw_rgb_out, hw_hsync_out, hw_vsync_out, pixel_valid, pixel_x, pixel_y,
             frame_start, frame_count};
        if (!rst_n || exp_q.size() == 0) e = idle_obs(mfc);
        else e = exp_q.pop_front();
        check("outputs", 64'(a), 64'(e));

        if (timing_chk) begin
            if (hw_hsync_out) hs_run++;
            else if (hs_run > 0) begin
                check("hsync_len", 64'(hs_run), 64'(HS));
                hs_pulses++;
                hs_run = 0;
            end
            if (hw_vsync_out) vs_run++;
            else if (vs_run > 0) begin
                check("vsync_len", 64'(vs_run), 64'(VS * HT));
                vs_pulses++;
                vs_run = 0;
            end
            if (frame_start) begin
                if (fs_cnt > 0) check("valid_per_frame", 64'(val_cnt), 64'(XR * YR));
                fs_cnt++;
                val_cnt = 0;
            end
            if (pixel_valid) val_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until the model's counters sit at (x,y), i.e. the next edge
    // processes that pixel.
    task automatic wait_xy(input int x, input int y);
        int n;
        n = 0;
        while (!(mh == x && mv == y) && n < 3 * HT * VT) begin
            tick(1);
            n++;
        end
        check("wait_xy", 64'((mh == x && mv == y) ? 1 : 0), 64'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(pixel_valid), 64'd0);
        check("rst_async_fc", 64'(frame_count), 64'd0);
        check("rst_async_rgb", 64'(hw_rgb_out), 64'd0);
        tick(2);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int r;
        // Reset, then idle with enable low.
        tick(5);
        rst_n = 1'b1;
        tick(100);
        @(negedge clk);
        check("idle_rgb", 64'(hw_rgb_out), 64'd0);
        check("idle_valid", 64'(pixel_valid), 64'd0);
        check("idle_sync", 64'({hw_hsync_out, hw_vsync_out}), 64'd0);
        check("idle_fc", 64'(frame_count), 64'd0);

        // Two clean frames with colour bars: timing measurements.
        tick(1);
        hs_run = 0; vs_run = 0; hs_pulses = 0; vs_pulses = 0; fs_cnt = 0; val_cnt = 0;
        timing_chk   = 1'b1;
        pattern_sel  = 2'd1;
        solid_colour = 16'h1234;
        enable       = 1'b1;
        n = 0;
        while (mfc != 2 && n < 3 * HT * VT) begin
            tick(1);
            n++;
        end
        check("reach_two_frames", 64'(mfc), 64'd2);
        repeat (3) @(negedge clk);
        check("fc_two", 64'(frame_count), 64'd2);
        check("fs_count", 64'(fs_cnt), 64'd3);
        check("hs_pulses", 64'(hs_pulses), 64'(2 * VT));
        check("vs_pulses", 64'(vs_pulses), 64'd2);
        timing_chk = 1'b0;
        tick(1);

        // Solid F800 frame, switch to bars mid-frame; bars start next frame.
        pattern_sel  = 2'd0;
        solid_colour = 16'hF800;
        wait_xy(0, 0);
        wait_xy(0, YR / 2);
        pattern_sel = 2'd1;
        wait_xy(1, 0);
        @(negedge clk);
        check("bars_after_switch", 64'({hw_rgb_out, pixel_x, pixel_y}), 64'({16'hFFFF, 11'd0, 11'd0}));
        tick(1);

        // Enable drop mid-line and re-enable.
        pattern_sel = 2'd2;
        wait_xy(XR / 2, 10);
        enable = 1'b0;
        tick(1);
        @(negedge clk);
        check("valid_after_disable", 64'(pixel_valid), 64'd0);
        tick(6);
        enable = 1'b1;
        tick(1);
        @(negedge clk);
        check("fs_after_reenable", 64'({frame_start, pixel_valid, pixel_x, pixel_y}), 64'({2'b11, 22'd0}));
        tick(1);

        // Reset pulse mid-line.
        pattern_sel = 2'd3;
        wait_xy(XR / 4, 12);
        pulse_reset();

        // Randomised pattern, colour, enable and reset activity.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(1, 60));
            r = $urandom_range(0, 19);
            if (r == 0) enable = 1'b0;
            else if (r <= 2) enable = 1'b1;
            else if (r <= 9) pattern_sel = 2'($urandom_range(0, 3));
            else if (r <= 17) solid_colour = 16'($urandom);
            else if (r == 18 && $urandom_range(0, 3) == 0) pulse_reset();
            if (!enable && $urandom_range(0, 1) == 1) begin
                tick($urandom_range(1, 10));
                enable = 1'b1;
            end
        end

        // A few full frames with a fresh pattern chosen per frame.
        enable = 1'b1;
        for (int f = 0; f < 4; f++) begin
            pattern_sel  = 2'($urandom_range(0, 3));
            solid_colour = 16'($urandom);
            wait_xy(0, 0);
            tick(1);
        end
        tick(HT);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
